// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock on q/qbar, MSB or LSB first, then pulses done for one cycle.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit.
`timescale 1ns/1ps
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             qbar,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             q_next;
    logic             done_next;
    logic             ready_next;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par, par_next;
`endif

    assign accept = load_valid && load_ready;
    assign busy   = (state != IDLE);

    // Next-state logic: load on accept, present one bit per edge, then finish.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        q_next     = 1'b0;
        done_next  = 1'b0;
        ready_next = 1'b0;
`ifdef PISO_PARITY_EN
        par_next   = par;
`endif
        unique case (state)
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    state_next = SHIFT;
                    shreg_next = din;
                    cnt_next   = CW'(WIDTH - 1);
                    q_next     = MSB_FIRST ? din[WIDTH-1] : din[0];
                    ready_next = 1'b0;
`ifdef PISO_PARITY_EN
                    par_next   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                    if (MSB_FIRST) begin
                        q_next     = shreg[WIDTH-2];
                        shreg_next = shreg << 1;
                    end else begin
                        q_next     = shreg[1];
                        shreg_next = shreg >> 1;
                    end
                end else begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
                    q_next     = par;
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
                    ready_next = 1'b1;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_next = IDLE;
                done_next  = 1'b1;
                ready_next = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // State and output registers; qbar is registered from the same next value as q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            q          <= 1'b0;
            qbar       <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            cnt        <= cnt_next;
            q          <= q_next;
            qbar       <= ~q_next;
            done       <= done_next;
            load_ready <= ready_next;
`ifdef PISO_PARITY_EN
            par        <= par_next;
`endif
        end
    end

endmodule
